// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, fetch-stage state and buffer entry types.
// No logic, no latency.
// No flow control; types only.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // Opcode field values seen by decode; opcode 0 is a real ADD, so bubbles
  // must be marked by instr_valid rather than a zero word.
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_JR   = 5'b01100;
  localparam logic [4:0] OP_JAL  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // One skid-buffer entry: the fetched word and the PC it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_ent_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: req/gnt address phase, in-order rvalid data phase.
// Address phase completes in the req&&gnt cycle; data returns >= 1 cycle later.
// Backpressure is gnt low; the data phase cannot be stalled by the requester.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO with push/pop/clear, count and full/empty flags.
// Head is combinational from storage; a push becomes visible at the head one edge later.
// Push when full is dropped unless a pop frees the slot the same cycle; clear beats push.
// Ports: clk, rst_n | i_push, i_push_dat, i_pop, i_clear | o_head_dat, o_count, o_full, o_empty
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [W-1:0]     o_head_dat,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read before the count says it was written.
  always_ff @(posedge clk) begin
    if (rst_n && !i_clear && w_push)
      r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches words into a skid buffer, drives the IF/ID register.
// Latency: req at edge N, rvalid at N+1 (1-cycle memory), instr_valid set at edge N+2.
// Backpressure: stall freezes IF/ID while the buffer fills; req drops once
//   outstanding + buffered reaches BUF_DEPTH or outstanding reaches MAX_OUTSTANDING.
// Ports: clk, rst_n | imem (req/addr/gnt/rvalid/rdata) | stall, flush, redirect_pc, hlt
//        | instr, PC_out, instr_valid
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              BUF_DEPTH       = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                flush,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                hlt,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     PC_out,
  output logic                instr_valid
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BUF_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic               w_run;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [OUT_W-1:0]   r_drop_cnt;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_out;
  logic               r_valid;

  logic               w_req;
  logic               w_fire;
  logic [OUT_W-1:0]   w_outstanding;
  logic [PC_W-1:0]    w_tag_pc;
  logic               w_tag_full;
  logic               w_tag_empty;
  fetch_ent_t         w_buf_in;
  fetch_ent_t         w_buf_head;
  logic [BUF_W-1:0]   w_buf_count;
  logic               w_buf_full;
  logic               w_buf_empty;
  logic               w_buf_push;
  logic               w_buf_pop;
  logic               w_buf_clear;

  // ---- FSM: state register / next state / outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    // A same-cycle redirect comes from an older instruction, so it cancels the halt.
    if (r_state == ST_RUN && hlt && !flush)
      w_state_nxt = ST_HALTED;
  end

  always_comb begin
    w_run = (r_state == ST_RUN);
  end

  // ---- Request side ----
  // Outstanding requests are exactly the entries in the PC tag queue.
  assign w_req = rst_n && w_run && !flush
              && ((32'(w_outstanding) + 32'(w_buf_count)) < 32'(BUF_DEPTH))
              && (32'(w_outstanding) < 32'(MAX_OUTSTANDING));
  assign w_fire    = w_req && imem.gnt;
  assign imem.req  = w_req;
  assign imem.addr = r_fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_fetch_pc <= RESET_PC;
    else if (flush)  r_fetch_pc <= redirect_pc;
    else if (w_fire) r_fetch_pc <= r_fetch_pc + 1'b1;
  end

  // Tag queue pops on every response, dropped or not, so it stays aligned with memory.
  fetch_buf #(.DEPTH(MAX_OUTSTANDING), .W(PC_W)) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_fire),
    .i_push_dat (r_fetch_pc),
    .i_pop      (imem.rvalid),
    .i_clear    (1'b0),
    .o_head_dat (w_tag_pc),
    .o_count    (w_outstanding),
    .o_full     (w_tag_full),
    .o_empty    (w_tag_empty)
  );

  // ---- Response side ----
  // After a redirect every request still in flight is stale; count them so they are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (flush)
      r_drop_cnt <= w_outstanding - OUT_W'(imem.rvalid);
    else if (imem.rvalid && r_drop_cnt != '0)
      r_drop_cnt <= r_drop_cnt - 1'b1;
  end

  assign w_buf_in    = '{pc: w_tag_pc, instr: imem.rdata};
  assign w_buf_push  = imem.rvalid && (r_drop_cnt == '0) && !flush;
  assign w_buf_clear = flush || (!stall && (hlt || !w_run));
  assign w_buf_pop   = !flush && !stall && !hlt && w_run;

  fetch_buf #(.DEPTH(BUF_DEPTH), .W($bits(fetch_ent_t))) u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_buf_push),
    .i_push_dat (w_buf_in),
    .i_pop      (w_buf_pop),
    .i_clear    (w_buf_clear),
    .o_head_dat (w_buf_head),
    .o_count    (w_buf_count),
    .o_full     (w_buf_full),
    .o_empty    (w_buf_empty)
  );

  // ---- IF/ID register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (hlt || !w_run) begin
      r_valid <= 1'b0;
    end else if (!w_buf_empty) begin
      r_instr  <= w_buf_head.instr;
      r_pc_out <= w_buf_head.pc;
      r_valid  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign instr       = r_instr;
  assign PC_out      = r_pc_out;
  assign instr_valid = r_valid;

  // ---- Protocol checks ----
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_buf_push && !w_buf_clear && w_buf_full && !(w_buf_pop && !w_buf_empty)));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_fire && w_tag_full && !imem.rvalid));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem.rvalid && w_tag_empty));
endmodule
